// File: rtl/imem_load_ctrl.sv
// Instruction-memory write-side controller: streams the boot program in, then shares the
// memory between IF reads and single-word debug writes, flushing fetch after each write.
module imem_load_ctrl #(
    parameter int unsigned INSTR_WIDTH     = 32,
    parameter int unsigned INSTR_MEM_DEPTH = 64,
    parameter int unsigned BOOT_WORDS      = INSTR_MEM_DEPTH,
    localparam int unsigned ADDR_WIDTH     = $clog2(INSTR_MEM_DEPTH)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_load_valid,
    input  logic [INSTR_WIDTH-1:0] i_load_data,
    input  logic                   i_load_last,
    output logic                   o_load_ready,
    input  logic                   i_dbg_wr_valid,
    input  logic [ADDR_WIDTH-1:0]  i_dbg_wr_addr,
    input  logic [INSTR_WIDTH-1:0] i_dbg_wr_data,
    output logic                   o_dbg_wr_ready,
    input  logic                   i_fetch_req,
    input  logic [ADDR_WIDTH+1:0]  i_fetch_addr,
    output logic                   o_mem_re,
    output logic                   o_mem_we,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    output logic [INSTR_WIDTH-1:0] o_mem_wdata,
    output logic                   o_fetch_stall,
    output logic                   o_fetch_flush,
    output logic                   o_boot_done,
    output logic                   o_load_err
);

    localparam logic [2:0] StInit  = 3'd0;
    localparam logic [2:0] StBoot  = 3'd1;
    localparam logic [2:0] StWrite = 3'd2;
    localparam logic [2:0] StFlush = 3'd3;
    localparam logic [2:0] StRun   = 3'd4;

    localparam logic [ADDR_WIDTH:0] CntLast = (ADDR_WIDTH + 1)'(BOOT_WORDS - 1);
    localparam logic [ADDR_WIDTH:0] DepthW  = (ADDR_WIDTH + 1)'(INSTR_MEM_DEPTH);

    logic [2:0]             state_q, state_d;
    logic [ADDR_WIDTH:0]    cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [INSTR_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                   wr_pend_q, wr_pend_d;
    logic                   wr_oor_q, wr_oor_d;
    logic                   boot_done_q, boot_done_d;
    logic                   load_err_q, load_err_d;

    logic load_acc, load_end, dbg_acc, late_load;

    assign load_acc  = (state_q == StBoot) & i_load_valid;
    assign load_end  = load_acc & (i_load_last | (cnt_q == CntLast));
    assign dbg_acc   = (state_q == StRun) & i_dbg_wr_valid;
    // WRITE/FLUSH/RUN are only reachable once the boot stream has completed
    assign late_load = i_load_valid &
                       ((state_q == StWrite) | (state_q == StFlush) | (state_q == StRun));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_pend_d   = 1'b0;
        wr_oor_d    = wr_oor_q;
        boot_done_d = boot_done_q;
        load_err_d  = load_err_q | late_load;
        case (state_q)
            StInit: state_d = StBoot;
            StBoot: begin
                if (load_acc) begin
                    wr_addr_d = cnt_q[ADDR_WIDTH-1:0];
                    wr_data_d = i_load_data;
                    wr_oor_d  = 1'b0;
                    cnt_d     = cnt_q + 1'b1;
                    // The completing beat is written by WRITE; earlier beats in the next BOOT cycle
                    if (load_end) state_d = StWrite;
                    else          wr_pend_d = 1'b1;
                end
            end
            StWrite: begin
                state_d     = StFlush;
                boot_done_d = 1'b1;
            end
            StFlush: state_d = StRun;
            StRun: begin
                if (dbg_acc) begin
                    wr_addr_d = i_dbg_wr_addr;
                    wr_data_d = i_dbg_wr_data;
                    wr_oor_d  = ({1'b0, i_dbg_wr_addr} >= DepthW);
                    state_d   = StWrite;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= StInit;
            cnt_q       <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_pend_q   <= 1'b0;
            wr_oor_q    <= 1'b0;
            boot_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_pend_q   <= wr_pend_d;
            wr_oor_q    <= wr_oor_d;
            boot_done_q <= boot_done_d;
            load_err_q  <= load_err_d;
        end
    end

    always_comb begin
        o_load_ready   = (state_q == StBoot);
        o_dbg_wr_ready = (state_q == StRun);
        o_fetch_stall  = (state_q != StRun);
        o_fetch_flush  = (state_q == StFlush);
        o_mem_we       = ((state_q == StBoot) & wr_pend_q) | ((state_q == StWrite) & ~wr_oor_q);
        o_mem_re       = (state_q == StRun) & i_fetch_req;
        o_mem_addr     = (state_q == StRun) ? i_fetch_addr[ADDR_WIDTH+1:2] : wr_addr_q;
        o_mem_wdata    = wr_data_q;
        o_boot_done    = boot_done_q;
        o_load_err     = load_err_q;
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: boot streaming, RUN fetch, debug writes, late-load error,
// out-of-range debug address and reset in the middle of a boot load.
module tb_imem_load_ctrl;

    localparam int unsigned IW = 32;
    localparam int unsigned AW = 6;  // $clog2(48)

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_valid = 1'b0;
    logic [IW-1:0] load_data = '0;
    logic          load_last = 1'b0;
    logic          load_ready;
    logic          dbg_valid = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [IW-1:0] dbg_data = '0;
    logic          dbg_ready;
    logic          fetch_req = 1'b0;
    logic [AW+1:0] fetch_addr = '0;
    logic          mem_re, mem_we, fetch_stall, fetch_flush, boot_done, load_err;
    logic [AW-1:0] mem_addr;
    logic [IW-1:0] mem_wdata;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    imem_load_ctrl #(
        .INSTR_WIDTH    (IW),
        .INSTR_MEM_DEPTH(48),
        .BOOT_WORDS     (8)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_load_valid  (load_valid),
        .i_load_data   (load_data),
        .i_load_last   (load_last),
        .o_load_ready  (load_ready),
        .i_dbg_wr_valid(dbg_valid),
        .i_dbg_wr_addr (dbg_addr),
        .i_dbg_wr_data (dbg_data),
        .o_dbg_wr_ready(dbg_ready),
        .i_fetch_req   (fetch_req),
        .i_fetch_addr  (fetch_addr),
        .o_mem_re      (mem_re),
        .o_mem_we      (mem_we),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .o_fetch_stall (fetch_stall),
        .o_fetch_flush (fetch_flush),
        .o_boot_done   (boot_done),
        .o_load_err    (load_err)
    );

    typedef struct {
        logic          v;
        logic [IW-1:0] d;
        logic          l;
        logic          rdy;
        logic          we;
        logic [AW-1:0] a;
        logic [IW-1:0] wd;
        logic          st;
        logic          fl;
        logic          dn;
    } boot_vec_t;

    typedef struct {
        logic          req;
        logic [AW+1:0] addr;
        logic          re;
        logic [AW-1:0] a;
    } fetch_vec_t;

    boot_vec_t  bt[8];
    fetch_vec_t ft[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int we_cnt;

    initial begin
        bt[0] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 6'd0, 32'h00, 1'b1, 1'b0, 1'b0};
        bt[1] = '{1'b1, 32'h11, 1'b0, 1'b1, 1'b0, 6'd0, 32'h00, 1'b1, 1'b0, 1'b0};
        bt[2] = '{1'b1, 32'h22, 1'b0, 1'b1, 1'b1, 6'd0, 32'h11, 1'b1, 1'b0, 1'b0};
        bt[3] = '{1'b1, 32'h33, 1'b0, 1'b1, 1'b1, 6'd1, 32'h22, 1'b1, 1'b0, 1'b0};
        bt[4] = '{1'b1, 32'h44, 1'b1, 1'b1, 1'b1, 6'd2, 32'h33, 1'b1, 1'b0, 1'b0};
        bt[5] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 6'd3, 32'h44, 1'b1, 1'b0, 1'b0};
        bt[6] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 6'd0, 32'h00, 1'b1, 1'b1, 1'b1};
        bt[7] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 6'd0, 32'h00, 1'b0, 1'b0, 1'b1};

        ft[0] = '{1'b1, 8'h0C, 1'b1, 6'd3};
        ft[1] = '{1'b1, 8'h0F, 1'b1, 6'd3};
        ft[2] = '{1'b1, 8'hBC, 1'b1, 6'd47};
        ft[3] = '{1'b0, 8'h08, 1'b0, 6'd2};

        // Reset state
        @(negedge clk);
        chk("rst.stall", 32'(fetch_stall), 32'd1);
        chk("rst.ready", 32'(load_ready), 32'd0);
        chk("rst.we_re", 32'({mem_we, mem_re}), 32'd0);
        chk("rst.flush_done_err", 32'({fetch_flush, boot_done, load_err}), 32'd0);
        chk("rst.addr_wdata", 32'(mem_addr) | mem_wdata, 32'd0);
        next_cycle();
        rst = 1'b0;

        // Boot 4 words back-to-back, last on word 4
        for (int i = 0; i < 8; i++) begin
            load_valid = bt[i].v;
            load_data  = bt[i].d;
            load_last  = bt[i].l;
            @(negedge clk);
            chk($sformatf("boot%0d.ready", i), 32'(load_ready), 32'(bt[i].rdy));
            chk($sformatf("boot%0d.we", i), 32'(mem_we), 32'(bt[i].we));
            chk($sformatf("boot%0d.re", i), 32'(mem_re), 32'd0);
            if (bt[i].we) begin
                chk($sformatf("boot%0d.addr", i), 32'(mem_addr), 32'(bt[i].a));
                chk($sformatf("boot%0d.wdata", i), mem_wdata, bt[i].wd);
            end
            chk($sformatf("boot%0d.stall", i), 32'(fetch_stall), 32'(bt[i].st));
            chk($sformatf("boot%0d.flush", i), 32'(fetch_flush), 32'(bt[i].fl));
            chk($sformatf("boot%0d.done", i), 32'(boot_done), 32'(bt[i].dn));
            next_cycle();
        end

        // RUN fetches: combinational read enable and word address
        for (int i = 0; i < 4; i++) begin
            fetch_req  = ft[i].req;
            fetch_addr = ft[i].addr;
            @(negedge clk);
            chk($sformatf("fetch%0d.re", i), 32'(mem_re), 32'(ft[i].re));
            chk($sformatf("fetch%0d.addr", i), 32'(mem_addr), 32'(ft[i].a));
            chk($sformatf("fetch%0d.stall", i), 32'(fetch_stall), 32'd0);
            chk($sformatf("fetch%0d.we", i), 32'(mem_we), 32'd0);
            next_cycle();
        end

        // Debug write with simultaneous fetch
        dbg_valid = 1'b1; dbg_addr = 6'd5; dbg_data = 32'hDEADBEEF;
        fetch_req = 1'b1; fetch_addr = 8'h08;
        @(negedge clk);
        chk("dbgN.ready", 32'(dbg_ready), 32'd1);
        chk("dbgN.re_addr", 32'({mem_re, mem_we, mem_addr}), 32'({1'b1, 1'b0, 6'd2}));
        next_cycle();
        // Held request during WRITE must not be taken
        dbg_addr = 6'd9; dbg_data = 32'h0BAD0BAD;
        @(negedge clk);
        chk("dbgN1.we", 32'({mem_we, mem_re}), 32'b10);
        chk("dbgN1.addr", 32'(mem_addr), 32'd5);
        chk("dbgN1.wdata", mem_wdata, 32'hDEADBEEF);
        chk("dbgN1.stall_ready", 32'({fetch_stall, dbg_ready}), 32'b10);
        next_cycle();
        dbg_valid = 1'b0;
        @(negedge clk);
        chk("dbgN2.flush", 32'({fetch_flush, fetch_stall, mem_we, mem_re}), 32'b1100);
        next_cycle();
        @(negedge clk);
        chk("dbgN3.run", 32'({fetch_stall, mem_re, mem_we}), 32'b010);
        next_cycle();
        @(negedge clk);
        chk("dbgN4.no_second_write", 32'({fetch_stall, mem_we}), 32'b00);
        next_cycle();

        // Out-of-range debug address: accepted, write suppressed, flush still occurs
        fetch_req = 1'b0;
        dbg_valid = 1'b1; dbg_addr = 6'd50; dbg_data = 32'h1234;
        @(negedge clk);
        chk("oor.ready", 32'(dbg_ready), 32'd1);
        next_cycle();
        dbg_valid = 1'b0;
        @(negedge clk);
        chk("oor.we_stall", 32'({mem_we, fetch_stall}), 32'b01);
        next_cycle();
        @(negedge clk);
        chk("oor.flush", 32'(fetch_flush), 32'd1);
        next_cycle();

        // Late boot beat in RUN
        load_valid = 1'b1; load_data = 32'h99;
        @(negedge clk);
        chk("lerr.ready_we", 32'({load_ready, mem_we}), 32'b00);
        chk("lerr.before", 32'(load_err), 32'd0);
        next_cycle();
        load_valid = 1'b0;
        @(negedge clk);
        chk("lerr.set", 32'(load_err), 32'd1);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("lerr.sticky", 32'(load_err), 32'd1);
        next_cycle();

        // Asynchronous reset clears sticky flags immediately
        #2 rst = 1'b1;
        #1;
        chk("arst.done_err", 32'({boot_done, load_err}), 32'd0);
        chk("arst.stall_ready", 32'({fetch_stall, dbg_ready}), 32'b10);
        next_cycle();
        rst = 1'b0;
        next_cycle();  // INIT -> BOOT
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1; load_data = 32'hA1 + 32'(i);
            next_cycle();
        end
        load_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst.we_ready", 32'({mem_we, load_ready}), 32'd0);
        chk("midrst.stall", 32'(fetch_stall), 32'd1);
        next_cycle();
        rst = 1'b0;
        next_cycle();  // INIT -> BOOT

        // Gapped boot, no last: completes after BOOT_WORDS=8 beats
        we_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            load_valid = 1'b1; load_data = 32'h100 + 32'(k);
            @(negedge clk);
            chk($sformatf("gap%0d.ready", k), 32'(load_ready), 32'd1);
            if (mem_we) we_cnt++;
            next_cycle();
            load_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("gap%0d.we_addr", k), 32'({mem_we, mem_addr}), 32'({1'b1, 6'(k)}));
            chk($sformatf("gap%0d.wdata", k), mem_wdata, 32'h100 + 32'(k));
            if (k == 7) chk("gap7.ready_low", 32'(load_ready), 32'd0);
            if (mem_we) we_cnt++;
            next_cycle();
        end
        @(negedge clk);
        chk("gap.flush_done", 32'({fetch_flush, boot_done, mem_we}), 32'b110);
        chk("gap.write_count", 32'(we_cnt), 32'd8);
        chk("gap.no_err", 32'(load_err), 32'd0);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
- Controller that owns the write side of the instruction memory and sequences the fetch stage around it.
- After reset it holds fetch stalled and streams a boot program into instruction memory through a valid/ready port.
- It then releases fetch, and afterwards shares the memory between IF reads and single-word debug writes.
- After every write burst it issues a one-cycle flush, so the IF stage never forwards a stale instruction.

Parameters:
- INSTR_WIDTH, 32, instruction word width.
- INSTR_MEM_DEPTH, 64, number of instruction words.
- ADDR_WIDTH, $clog2(INSTR_MEM_DEPTH), word-index width. Not user-modifiable.
- BOOT_WORDS, INSTR_MEM_DEPTH, maximum number of boot-load beats before automatic completion. Must satisfy 1 <= BOOT_WORDS <= INSTR_MEM_DEPTH.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_reset  in  1  asynchronous reset, active-high.
- i_load_valid  in  1  boot stream beat valid.
- i_load_data  in  INSTR_WIDTH  boot stream instruction word.
- i_load_last  in  1  marks the final boot beat, for early completion.
- o_load_ready  out  1  boot beat accepted when high with i_load_valid.
- i_dbg_wr_valid  in  1  debug write request.
- i_dbg_wr_addr  in  ADDR_WIDTH  debug write word index.
- i_dbg_wr_data  in  INSTR_WIDTH  debug write data.
- o_dbg_wr_ready  out  1  debug write accepted when high with i_dbg_wr_valid.
- i_fetch_req  in  1  IF read request.
- i_fetch_addr  in  ADDR_WIDTH+2  IF byte address. Word index is [ADDR_WIDTH+1:2]; bits [1:0] are ignored.
- o_mem_re  out  1  memory read enable.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  ADDR_WIDTH  memory word address.
- o_mem_wdata  out  INSTR_WIDTH  memory write data.
- o_fetch_stall  out  1  IF must hold its PC and pipeline register.
- o_fetch_flush  out  1  IF must replace its output instruction with NOP (0x00000013).
- o_boot_done  out  1  sticky; high once the boot load completes.
- o_load_err  out  1  sticky; set when i_load_valid is seen after boot completion.

Behaviour:
- States:
  - INIT: one cycle, everything quiet.
  - BOOT: boot stream accepted.
  - WRITE: registered write cycle.
  - FLUSH: one-cycle fetch invalidate.
  - RUN: normal fetch.
- Reset:
  - While i_reset is high, state = INIT, load counter = 0, write holding register = 0.
  - All outputs are 0, except o_fetch_stall = 1.
- Transitions:
  - INIT goes to BOOT unconditionally.
- BOOT:
  - o_load_ready = 1, o_fetch_stall = 1, o_mem_re = 0.
  - A beat is accepted on i_load_valid & o_load_ready.
  - The accepted word is written in the next cycle: o_mem_we = 1, o_mem_addr = counter value at acceptance, o_mem_wdata = that word.
  - The counter increments by 1 per accepted beat.
  - Back-to-back beats give one write per cycle, with the write pipelined one cycle behind acceptance.
  - Completion occurs when the accepted beat has i_load_last = 1 or counter == BOOT_WORDS-1. The next state is then WRITE, which performs the final write.
- WRITE:
  - o_mem_we = 1 with the held address and data.
  - o_fetch_stall = 1, o_load_ready = 0, o_dbg_wr_ready = 0.
  - Next state is FLUSH.
- FLUSH:
  - o_fetch_flush = 1, o_fetch_stall = 1, no memory access.
  - Next state is RUN.
  - o_boot_done sets in the FLUSH cycle that follows a boot load and stays set until reset.
- RUN:
  - o_fetch_stall = 0.
  - o_mem_re = i_fetch_req and o_mem_addr = i_fetch_addr[ADDR_WIDTH+1:2], both combinational.
  - o_dbg_wr_ready = 1 in RUN only.
  - On i_dbg_wr_valid the request is accepted: address and data are latched and the next state is WRITE.
  - A fetch in the acceptance cycle is still served.
- Debug write latency: acceptance at cycle N, write at N+1, flush at N+2, fetch resumes at N+3.
- Simultaneous events:
  - i_dbg_wr_valid asserted during BOOT/WRITE/FLUSH/INIT is not accepted; ready stays 0 and the requester holds.
  - A debug write and a fetch in the same RUN cycle are both honoured: read now, write next cycle.
- i_load_valid asserted in RUN, WRITE or FLUSH after boot completion:
  - The data is ignored and o_load_ready stays 0.
  - o_load_err sets on the next edge and stays set until reset.
- Out-of-range debug address (>= INSTR_MEM_DEPTH, non-power-of-2 depth only): the request is accepted but o_mem_we is suppressed in WRITE. FLUSH still occurs.
- Counter: ADDR_WIDTH+1 bits wide, so it never wraps before completion.
- Reset mid-operation: asynchronous return to INIT from any state.
  - o_boot_done and o_load_err clear.
  - A partial boot load is abandoned, and loading restarts at word 0.
- o_mem_we and o_mem_re are never both 1 in the same cycle.

Test Plan:
- Boot 4 words 0x11,0x22,0x33,0x44 back-to-back, last on word 4 -> writes at addr 0..3 in cycles 2..5 after INIT; one FLUSH cycle with o_fetch_flush=1; o_boot_done=1; o_fetch_stall falls the next cycle.
- Boot with BOOT_WORDS=8, i_load_last never asserted, valid gapped every other cycle -> exactly 8 writes to addr 0..7; o_load_ready=0 after the 8th beat.
- In RUN, i_fetch_req=1 with i_fetch_addr=0x0C -> o_mem_re=1, o_mem_addr=3 in the same cycle, stall=0.
- In RUN, i_dbg_wr_valid with addr 5 and data 0xDEADBEEF plus a simultaneous fetch of 0x08 -> read of addr 2 at N; write of addr 5 at N+1 with stall=1; flush at N+2; stall=0 at N+3.
- In RUN, i_load_valid=1 -> no write; o_load_err=1 the next cycle and it stays high.
- Assert i_reset mid-boot after 3 beats -> outputs clear immediately; after release, the first accepted beat writes addr 0.
